// File: rtl/mem_axi_master_pkg.sv
// Shared definitions for the MEM-stage AXI4-Lite master.
//   state_e      : FSM state encoding for mem_axi_master
//   Resp*        : AXI response codes (only OKAY counts as success)
package mem_axi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/mem_axi_master.sv
// Single-outstanding AXI4-Lite master bridging the core MEM stage to the cache slave.
// One access at a time: a load runs AR then R, a store runs AW and W (independently,
// in any order) then B. Completion is a one-cycle resp_valid pulse on return to idle.
//
// Ports
//   clk, rstn                 : clock, asynchronous active-low reset
//   req_valid/ready/we        : core request handshake and direction (1 = store)
//   req_addr/wdata/wstrb      : request payload, latched on accept
//   resp_valid/rdata/err      : completion pulse, load data (held), non-OKAY flag
//   m_ar*/m_r*/m_aw*/m_w*/m_b*: AXI4-Lite master channels
module mem_axi_master
  import mem_axi_master_pkg::*;
#(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rstn,
  // core side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AR
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  output logic [2:0]  m_arprot,
  input  logic        m_arready,
  // R
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // AW
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  output logic [2:0]  m_awprot,
  input  logic        m_awready,
  // W
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  // B
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        latch_req;

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    latch_req    = 1'b0;
    req_ready    = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    m_bready     = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_req = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? StWrReq : StRdAddr;
        end
      end
      StRdAddr: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = StRdData;
      end
      StRdData: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = m_rdata;
          resp_err_d   = (m_rresp != RespOkay);
          state_d      = StIdle;
        end
      end
      StWrReq: begin
        // Each valid stays up only until its own handshake has been seen.
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        if (!aw_done_q && m_awready) aw_done_d = 1'b1;
        if (!w_done_q && m_wready)   w_done_d  = 1'b1;
        // Uses the _d flags so a handshake completing this cycle counts.
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = (m_bresp != RespOkay);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if (latch_req) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Payload comes straight from the latched request, so it cannot move while a valid is up.
  assign m_araddr   = addr_q;
  assign m_awaddr   = addr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;
  assign m_arprot   = PROT;
  assign m_awprot   = PROT;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_axi_master.sv
module tb_mem_axi_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2:0]  m_arprot, m_awprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_rresp, m_bresp;

  always #5 clk = ~clk;

  mem_axi_master #(.PROT(3'b000)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arprot(m_arprot), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awprot(m_awprot), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Slave behaviour: each channel becomes ready/valid after a configured number of cycles.
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          rd_pend, aw_seen, w_seen, b_pend;

  // Observed traffic.
  int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0, n_acc = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  bit          ar_stall, aw_stall, w_stall;
  logic [31:0] ar_hold, aw_hold, w_hold;
  logic [3:0]  ws_hold;

  // Model of the load-data register as seen by the core.
  logic [31:0] model_rdata = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_rvalid  = 1'b0; m_bvalid  = 1'b0;
    end else begin
      m_arready = m_arvalid && (ar_cnt >= ar_dly);
      m_awready = m_awvalid && (aw_cnt >= aw_dly);
      m_wready  = m_wvalid && (w_cnt >= w_dly);
      m_rvalid  = rd_pend && (r_cnt >= r_dly);
      m_bvalid  = b_pend && (b_cnt >= b_dly);
    end
    m_rdata = cfg_rdata;
    m_rresp = cfg_rresp;
    m_bresp = cfg_bresp;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      rd_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_stall = 0; aw_stall = 0; w_stall = 0;
    end else begin
      if (req_valid && req_ready) n_acc++;
      if (resp_valid) n_resp++;
      // Payload must hold while a valid waits for its ready.
      if (ar_stall) begin
        n_checks++;
        if (!(m_arvalid === 1'b1 && m_araddr === ar_hold))
          $display("FAIL ar_stable: valid=%b addr=%h required valid=1 addr=%h",
                   m_arvalid, m_araddr, ar_hold);
        else n_pass++;
      end
      if (aw_stall) begin
        n_checks++;
        if (!(m_awvalid === 1'b1 && m_awaddr === aw_hold))
          $display("FAIL aw_stable: valid=%b addr=%h required valid=1 addr=%h",
                   m_awvalid, m_awaddr, aw_hold);
        else n_pass++;
      end
      if (w_stall) begin
        n_checks++;
        if (!(m_wvalid === 1'b1 && m_wdata === w_hold && m_wstrb === ws_hold))
          $display("FAIL w_stable: valid=%b data=%h strb=%h required valid=1 data=%h strb=%h",
                   m_wvalid, m_wdata, m_wstrb, w_hold, ws_hold);
        else n_pass++;
      end
      ar_stall = m_arvalid && !m_arready; ar_hold = m_araddr;
      aw_stall = m_awvalid && !m_awready; aw_hold = m_awaddr;
      w_stall  = m_wvalid && !m_wready;   w_hold = m_wdata; ws_hold = m_wstrb;
      // Response channels first so a fresh pending request starts with a zero count.
      if (m_rvalid && m_rready) begin n_r++; rd_pend = 0; end
      else if (rd_pend) r_cnt++;
      if (m_bvalid && m_bready) begin n_b++; b_pend = 0; end
      else if (b_pend) b_cnt++;
      if (m_arvalid && m_arready) begin
        n_ar++; last_araddr = m_araddr; ar_cnt = 0; rd_pend = 1; r_cnt = 0;
      end else if (m_arvalid) ar_cnt++;
      if (m_awvalid && m_awready) begin
        n_aw++; last_awaddr = m_awaddr; aw_cnt = 0; aw_seen = 1;
      end else if (m_awvalid) aw_cnt++;
      if (m_wvalid && m_wready) begin
        n_w++; last_wdata = m_wdata; last_wstrb = m_wstrb; w_cnt = 0; w_seen = 1;
      end else if (m_wvalid) w_cnt++;
      if (aw_seen && w_seen) begin
        aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0;
      end
    end
  end

  // Issues one access; lat counts cycles from the accept cycle to the resp_valid cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output int lat, output bit ok);
    int guard;
    ok = 0;
    lat = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
    ok = resp_valid;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #1;
    n_checks++;
    if ({req_ready, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid, resp_err}
        !== 8'b1000_0000)
      $display("FAIL reset_ctrl: got %b required 10000000",
               {req_ready, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid,
                resp_err});
    else n_pass++;
    n_checks++;
    if (resp_rdata !== 32'h0 || m_araddr !== 32'h0 || m_arprot !== 3'b000)
      $display("FAIL reset_data: rdata=%h araddr=%h arprot=%b required 0 0 000",
               resp_rdata, m_araddr, m_arprot);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_load_basic();
    int lat; bit ok;
    ar_dly = 0; r_dly = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, ok);
    model_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (!ok || lat !== 3) $display("FAIL load_latency: got %0d (ok=%0b) required 3", lat, ok);
    else n_pass++;
    n_checks++;
    if (resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0 || last_araddr !== 32'h8000_0010)
      $display("FAIL load_data: rdata=%h err=%b araddr=%h required deadbeef 0 80000010",
               resp_rdata, resp_err, last_araddr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL load_pulse: resp_valid=%b required 0", resp_valid);
    else n_pass++;
  endtask

  task automatic test_store_order();
    int aw_t[3] = '{0, 0, 1};
    int w_t[3]  = '{2, 0, 1};
    int lat; bit ok;
    int ar0, aw0, w0, b0, rs0;
    for (int i = 0; i < 3; i++) begin
      aw_dly = aw_t[i]; w_dly = w_t[i]; b_dly = 0; cfg_bresp = 2'b00;
      if (i == 1) aw_dly = 3;
      ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b; rs0 = n_resp;
      issue(1'b1, 32'h8000_0020 + 32'(i * 4), 32'h1234_5678 + 32'(i), 4'b0011, lat, ok);
      @(negedge clk);
      n_checks++;
      if (!ok || lat !== 3 + ((aw_dly > w_dly) ? aw_dly : w_dly))
        $display("FAIL store_latency[%0d]: got %0d (ok=%0b) required %0d", i, lat, ok,
                 3 + ((aw_dly > w_dly) ? aw_dly : w_dly));
      else n_pass++;
      n_checks++;
      if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1 || n_ar - ar0 !== 0 ||
          n_resp - rs0 !== 1)
        $display("FAIL store_beats[%0d]: aw=%0d w=%0d b=%0d ar=%0d resp=%0d required 1 1 1 0 1",
                 i, n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0, n_resp - rs0);
      else n_pass++;
      n_checks++;
      if (last_awaddr !== 32'h8000_0020 + 32'(i * 4) || last_wdata !== 32'h1234_5678 + 32'(i)
          || last_wstrb !== 4'b0011 || resp_err !== 1'b0)
        $display("FAIL store_payload[%0d]: addr=%h data=%h strb=%b err=%b", i, last_awaddr,
                 last_wdata, last_wstrb, resp_err);
      else n_pass++;
    end
  endtask

  task automatic test_load_err_stall();
    int lat; bit ok; int ar0;
    ar_dly = 5; r_dly = 0; cfg_rdata = 32'hA5A5_0001; cfg_rresp = 2'b10;
    ar0 = n_ar;
    issue(1'b0, 32'h8000_0100, 32'h0, 4'h0, lat, ok);
    model_rdata = 32'hA5A5_0001;
    n_checks++;
    if (!ok || lat !== 8) $display("FAIL err_latency: got %0d (ok=%0b) required 8", lat, ok);
    else n_pass++;
    n_checks++;
    if (resp_err !== 1'b1 || n_ar - ar0 !== 1 || last_araddr !== 32'h8000_0100)
      $display("FAIL err_resp: err=%b ar_beats=%0d addr=%h required 1 1 80000100",
               resp_err, n_ar - ar0, last_araddr);
    else n_pass++;
    cfg_rresp = 2'b00; ar_dly = 0;
  endtask

  task automatic test_back_to_back();
    int acc0, ar0, aw0, guard, lat2; bit early;
    aw_dly = 1; w_dly = 2; b_dly = 1; ar_dly = 0; r_dly = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0BAD_F00D;
    acc0 = n_acc; ar0 = n_ar; aw0 = n_aw; early = 0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h8000_0200; req_wdata = 32'hCAFE_0000; req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h8000_0300;
    guard = 0;
    while (!resp_valid && guard < 100) begin
      if (req_ready) early = 1;
      @(negedge clk); guard++;
    end
    n_checks++;
    if (!resp_valid || early || req_ready !== 1'b1)
      $display("FAIL b2b_hold: resp=%b early_ready=%b ready=%b required 1 0 1",
               resp_valid, early, req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    lat2 = 1;
    while (!resp_valid && lat2 < 100) begin @(negedge clk); lat2++; end
    model_rdata = 32'h0BAD_F00D;
    n_checks++;
    if (lat2 !== 3 || resp_rdata !== 32'h0BAD_F00D || last_araddr !== 32'h8000_0300)
      $display("FAIL b2b_second: lat=%0d rdata=%h addr=%h required 3 0badf00d 80000300",
               lat2, resp_rdata, last_araddr);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_acc - acc0 !== 2 || n_ar - ar0 !== 1 || n_aw - aw0 !== 1)
      $display("FAIL b2b_count: accepts=%0d ar=%0d aw=%0d required 2 1 1",
               n_acc - acc0, n_ar - ar0, n_aw - aw0);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, exp_lat; bit ok; logic we; logic [31:0] addr, wdata; logic [3:0] strb;
    int ar0, r0, aw0, w0, b0;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom; strb = 4'($urandom_range(0, 15));
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      cfg_rdata = $urandom; cfg_rresp = 2'($urandom_range(0, 3));
      cfg_bresp = 2'($urandom_range(0, 3));
      ar0 = n_ar; r0 = n_r; aw0 = n_aw; w0 = n_w; b0 = n_b;
      exp_lat = we ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      if (!we) model_rdata = cfg_rdata;
      issue(we, addr, wdata, strb, lat, ok);
      n_checks++;
      if (!ok || lat !== exp_lat)
        $display("FAIL rand_latency[%0d]: got %0d (ok=%0b) required %0d", i, lat, ok, exp_lat);
      else n_pass++;
      n_checks++;
      if (resp_err !== ((we ? cfg_bresp : cfg_rresp) != 2'b00) || resp_rdata !== model_rdata)
        $display("FAIL rand_resp[%0d]: err=%b rdata=%h required err=%b rdata=%h", i, resp_err,
                 resp_rdata, ((we ? cfg_bresp : cfg_rresp) != 2'b00), model_rdata);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (we ? (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1 || n_ar - ar0 !== 0 ||
                last_awaddr !== addr || last_wdata !== wdata || last_wstrb !== strb)
             : (n_ar - ar0 !== 1 || n_r - r0 !== 1 || n_aw - aw0 !== 0 || last_araddr !== addr))
        $display("FAIL rand_beats[%0d]: we=%b ar=%0d r=%0d aw=%0d w=%0d b=%0d addr=%h", i, we,
                 n_ar - ar0, n_r - r0, n_aw - aw0, n_w - w0, n_b - b0, addr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int guard, resp0, r0, lat; bit ok;
    ar_dly = 0; r_dly = 20; cfg_rresp = 2'b00; cfg_rdata = 32'h1111_2222;
    resp0 = n_resp; r0 = n_r;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h8000_0400; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!m_rready && guard < 50) begin @(negedge clk); guard++; end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid, req_ready}
        !== 7'b0000001 || guard >= 50)
      $display("FAIL midreset_async: got %b (guard=%0d) required 0000001",
               {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid, req_ready},
               guard);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    model_rdata = 32'h0;
    r_dly = 0; cfg_rdata = 32'h3333_4444;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || n_resp !== resp0 || n_r !== r0)
      $display("FAIL midreset_abandon: ready=%b resp=%0d r=%0d required 1 0 0", req_ready,
               n_resp - resp0, n_r - r0);
    else n_pass++;
    issue(1'b0, 32'h8000_0500, 32'h0, 4'h0, lat, ok);
    n_checks++;
    if (!ok || lat !== 3 || resp_rdata !== 32'h3333_4444)
      $display("FAIL midreset_reload: lat=%0d ok=%0b rdata=%h required 3 1 33334444", lat, ok,
               resp_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_order();
    test_load_err_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_axi_master.md
MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 Parameter PROT, default 3'b000: constant value driven on m_arprot and m_awprot.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core MEM stage presents an access.
REQ-005 req_ready  output  1  block idle and able to accept an access.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address, forwarded unmodified.
REQ-008 req_wdata  input  32  store data, lane-aligned by the core.
REQ-009 req_wstrb  input  4  store byte enables.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load data; valid with resp_valid on loads.
REQ-012 resp_err  output  1  AXI response was not OKAY (2'b00).
REQ-013 AR: m_araddr out 32, m_arvalid out 1, m_arprot out 3, m_arready in 1.
REQ-014 R: m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1.
REQ-015 AW: m_awaddr out 32, m_awvalid out 1, m_awprot out 3, m_awready in 1.
REQ-016 W: m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1.
REQ-017 B: m_bresp in 2, m_bvalid in 1, m_bready out 1.

Function
REQ-018 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-019 req_ready is 1 only in IDLE; accept = req_valid && req_ready; inputs latched on accept.
REQ-020 Load accept: IDLE -> RD_ADDR; m_arvalid = 1 from the next cycle, with latched address.
REQ-021 RD_ADDR: m_arvalid held with stable m_araddr until m_arready; handshake -> RD_DATA, m_arvalid = 0.
REQ-022 RD_DATA: m_rready = 1; on m_rvalid capture m_rdata/m_rresp -> IDLE.
REQ-023 Store accept: IDLE -> WR_REQ; m_awvalid and m_wvalid both = 1 from the next cycle.
REQ-024 WR_REQ: AW and W tracked independently; each valid drops the cycle after its own handshake; handshakes may occur together or in either order.
REQ-025 WR_REQ -> WR_RESP once both AW and W have completed; a same-cycle handshake of the last channel counts.
REQ-026 WR_RESP: m_bready = 1; on m_bvalid capture m_bresp -> IDLE.
REQ-027 resp_valid pulses for exactly one cycle, the cycle after the R or B handshake, coincident with return to IDLE (req_ready = 1).
REQ-028 resp_err = (captured resp != 2'b00); resp_rdata holds the last load data until the next load completes; it is don't-care on stores.
REQ-029 Minimum latency with a zero-wait slave: load accept to resp_valid = 3 cycles; store = 3 cycles.
REQ-030 req_valid while busy is ignored; no queueing and no outstanding-transaction overlap.
REQ-031 m_awaddr/m_wdata/m_wstrb/m_araddr stay stable while the corresponding valid is high (AXI rule).
REQ-032 Slave stalls of any length on any channel are tolerated; there is no timeout.

Reset
REQ-033 On rstn low, immediately: state = IDLE; m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid, resp_err = 0; resp_rdata and latched request = 0.
REQ-034 Reset mid-transaction abandons the access; no resp_valid for it; req_ready = 1 on the first cycle after release.

Structure
REQ-035 State encoding enum and AXI response constants (OKAY = 2'b00) go in a shared core package.
REQ-036 Single flat module, no sub-module; output ports connect directly to the cache slave (s_*) ports.

Verification
REQ-037 Load 0x8000_0010, slave with ready always high, rdata 0xDEAD_BEEF, rresp 00 -> resp_valid 3 cycles after accept, resp_rdata 0xDEAD_BEEF, resp_err 0.
REQ-038 Store 0x8000_0020, data 0x1234_5678, wstrb 4'b0011; awready 2 cycles before wready -> single AW and W beats with correct values, one B handshake, resp_valid once.
REQ-039 Store with wready before awready, and a store with both in the same cycle -> each channel handshakes exactly once; enters WR_RESP correctly.
REQ-040 Load with rresp 2'b10 and arready stalled 5 cycles -> m_araddr stable throughout, resp_err 1.
REQ-041 req_valid held high during a busy store -> second access is accepted only after resp_valid; there are exactly two transactions.
REQ-042 rstn asserted in RD_DATA -> all valids and readies drop asynchronously, no resp_valid, and a new load is accepted immediately after release.
